// File: rtl/mem_arbiter_if.sv
// Signal bundle between the fetch/data requesters, the arbiter and mem_system.
// Requesters hold rd/wr level-high until their one-cycle done pulse; memory ends a transaction with mem_done or mem_err.
interface mem_arbiter_if;
  logic        if_rd;
  logic [15:0] if_addr;
  logic [15:0] if_data;
  logic        if_done;
  logic        if_err;
  logic        if_stall;

  logic        dm_rd;
  logic        dm_wr;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic [15:0] dm_data;
  logic        dm_done;
  logic        dm_err;
  logic        dm_stall;

  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_done;
  logic        mem_err;

  modport slave (
    input  if_rd, if_addr,
    input  dm_rd, dm_wr, dm_addr, dm_wdata,
    input  mem_rdata, mem_done, mem_err,
    output if_data, if_done, if_err, if_stall,
    output dm_data, dm_done, dm_err, dm_stall,
    output mem_rd, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output if_rd, if_addr,
    output dm_rd, dm_wr, dm_addr, dm_wdata,
    output mem_rdata, mem_done, mem_err,
    input  if_data, if_done, if_err, if_stall,
    input  dm_data, dm_done, dm_err, dm_stall,
    input  mem_rd, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises fetch and data-stage requests onto one mem_system port; data wins
// by default, with fetch starvation bounded to DM_BURST consecutive data grants.
module mem_arbiter #(
  parameter int DM_BURST = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  mem_arbiter_if.slave                     bus,
  output logic [1:0]                       dbg_state,
  output logic [$clog2(DM_BURST+1)-1:0]    dbg_dm_run
);

  localparam int RUN_W = $clog2(DM_BURST + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(DM_BURST);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_DM = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [RUN_W-1:0] dm_run;
  logic             dm_req;
  logic             fin;
  logic             grant_if;
  logic             grant_dm;

  assign dm_req = bus.dm_rd | bus.dm_wr;
  // An error completes the transaction exactly like mem_done.
  assign fin    = bus.mem_done | bus.mem_err;

  assign bus.if_stall = bus.if_rd & ~bus.if_done;
  assign bus.dm_stall = dm_req & ~bus.dm_done;

  assign dbg_state  = state;
  assign dbg_dm_run = dm_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_dm  = 1'b0;
    case (state)
      IDLE: begin
        if (dm_req && (!bus.if_rd || (dm_run < RUN_MAX))) begin
          grant_dm  = 1'b1;
          state_nxt = GNT_DM;
        end else if (bus.if_rd) begin
          grant_if  = 1'b1;
          state_nxt = GNT_IF;
        end
      end
      GNT_IF, GNT_DM: begin
        if (fin) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counts data grants taken while fetch waits; an idle fetch side resets the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dm_run <= '0;
    end else if (grant_if) begin
      dm_run <= '0;
    end else if (grant_dm) begin
      if (!bus.if_rd) begin
        dm_run <= '0;
      end else if (dm_run != RUN_MAX) begin
        dm_run <= dm_run + 1'b1;
      end
    end
  end

  // mem_rd/mem_wr double as the latched op for the whole grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_rd    <= 1'b0;
      bus.mem_wr    <= 1'b0;
      bus.mem_addr  <= 16'h0000;
      bus.mem_wdata <= 16'h0000;
    end else if (grant_dm) begin
      bus.mem_addr  <= bus.dm_addr;
      bus.mem_wdata <= bus.dm_wdata;
      bus.mem_wr    <= bus.dm_wr;
      bus.mem_rd    <= ~bus.dm_wr;
    end else if (grant_if) begin
      bus.mem_addr  <= bus.if_addr;
      bus.mem_wr    <= 1'b0;
      bus.mem_rd    <= 1'b1;
    end else if (((state == GNT_IF) || (state == GNT_DM)) && fin) begin
      bus.mem_rd    <= 1'b0;
      bus.mem_wr    <= 1'b0;
    end
  end

  // Done/err are set on the completion edge, so they are high only during RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.if_done <= 1'b0;
      bus.if_err  <= 1'b0;
      bus.if_data <= 16'h0000;
      bus.dm_done <= 1'b0;
      bus.dm_err  <= 1'b0;
      bus.dm_data <= 16'h0000;
    end else begin
      bus.if_done <= (state == GNT_IF) && fin;
      bus.if_err  <= (state == GNT_IF) && bus.mem_err;
      bus.dm_done <= (state == GNT_DM) && fin;
      bus.dm_err  <= (state == GNT_DM) && bus.mem_err;
      if ((state == GNT_IF) && fin) begin
        bus.if_data <= bus.mem_rdata;
      end
      if ((state == GNT_DM) && fin && bus.mem_rd) begin
        bus.dm_data <= bus.mem_rdata;
      end
    end
  end

  a_one_op: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.mem_rd && bus.mem_wr));
  a_if_done_resp: assert property (@(posedge clk) disable iff (!rst_n)
    bus.if_done |-> (state == RESP));
  a_dm_done_resp: assert property (@(posedge clk) disable iff (!rst_n)
    bus.dm_done |-> (state == RESP));
  a_run_bound: assert property (@(posedge clk) disable iff (!rst_n)
    dm_run <= RUN_MAX);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table of single transactions plus
// hand-written sequences for contention, burst fairness and mid-grant reset.
module tb_mem_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  logic [1:0] dbg_dm_run;
  int         checks;
  int         errors;

  mem_arbiter_if bus();

  mem_arbiter #(.DM_BURST(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .dbg_state  (dbg_state),
    .dbg_dm_run (dbg_dm_run)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        is_dm;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          k;
    logic        mem_d;
    logic        mem_e;
    logic [15:0] rdata;
    logic        exp_rd;
    logic        exp_wr;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[7];
  logic [1:0] exp_q[$];
  logic [1:0] run_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.if_rd = 1'b0; bus.if_addr = 16'h0000;
    bus.dm_rd = 1'b0; bus.dm_wr = 1'b0; bus.dm_addr = 16'h0000; bus.dm_wdata = 16'h0000;
    bus.mem_rdata = 16'h0000; bus.mem_done = 1'b0; bus.mem_err = 1'b0;
  endtask

  // One transaction from a single requester, starting in an IDLE cycle.
  task automatic run_txn(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    if (v.is_dm) begin
      bus.dm_rd = v.rd; bus.dm_wr = v.wr; bus.dm_addr = v.addr; bus.dm_wdata = v.wdata;
    end else begin
      bus.if_rd = 1'b1; bus.if_addr = v.addr;
    end
    #1;
    chk({tag, "_stall0"}, v.is_dm ? bus.dm_stall : bus.if_stall, 1);
    tick();
    chk({tag, "_mem_rd"}, bus.mem_rd, v.exp_rd);
    chk({tag, "_mem_wr"}, bus.mem_wr, v.exp_wr);
    chk({tag, "_mem_addr"}, bus.mem_addr, v.addr);
    if (v.wr) chk({tag, "_mem_wdata"}, bus.mem_wdata, v.wdata);
    // scramble requester inputs; the latched copies must not move
    if (v.is_dm) begin bus.dm_addr = ~v.addr; bus.dm_wdata = ~v.wdata; end
    else bus.if_addr = ~v.addr;
    for (int w = 0; w < v.k; w++) begin
      tick();
      chk({tag, "_wait_op"}, {bus.mem_rd, bus.mem_wr}, {v.exp_rd, v.exp_wr});
      chk({tag, "_wait_addr"}, bus.mem_addr, v.addr);
      chk({tag, "_wait_stall"}, v.is_dm ? bus.dm_stall : bus.if_stall, 1);
    end
    bus.mem_done = v.mem_d; bus.mem_err = v.mem_e; bus.mem_rdata = v.rdata;
    tick();
    bus.mem_done = 1'b0; bus.mem_err = 1'b0; bus.mem_rdata = 16'h0000;
    chk({tag, "_done"}, v.is_dm ? bus.dm_done : bus.if_done, 1);
    chk({tag, "_other_done"}, v.is_dm ? bus.if_done : bus.dm_done, 0);
    chk({tag, "_err"}, v.is_dm ? bus.dm_err : bus.if_err, v.mem_e);
    chk({tag, "_data"}, v.is_dm ? bus.dm_data : bus.if_data, v.exp_data);
    chk({tag, "_resp_op"}, {bus.mem_rd, bus.mem_wr}, 2'b00);
    chk({tag, "_resp_stall"}, v.is_dm ? bus.dm_stall : bus.if_stall, 0);
    drive_idle();
    tick();
    chk({tag, "_idle_done"}, {bus.if_done, bus.dm_done, bus.if_err, bus.dm_err}, 4'b0000);
    chk({tag, "_hold_data"}, v.is_dm ? bus.dm_data : bus.if_data, v.exp_data);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive_idle();

    vecs[0] = '{1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2, 1'b1, 1'b0, 16'h1234, 1'b1, 1'b0, 16'h1234};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 16'h0040, 16'hBEEF, 1, 1'b1, 1'b0, 16'h9999, 1'b0, 1'b1, 16'h0000};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 16'h0100, 16'h0000, 0, 1'b1, 1'b0, 16'hA5A5, 1'b1, 1'b0, 16'hA5A5};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 16'h0200, 16'h0000, 1, 1'b1, 1'b1, 16'h5A5A, 1'b1, 1'b0, 16'h5A5A};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 0, 1'b1, 1'b0, 16'h0F0F, 1'b1, 1'b0, 16'h0F0F};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 16'h0300, 16'h1111, 0, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b1, 16'h5A5A};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000, 3, 1'b0, 1'b1, 16'hCAFE, 1'b1, 1'b0, 16'hCAFE};

    // reset state
    tick();
    chk("rst_op", {bus.mem_rd, bus.mem_wr}, 2'b00);
    chk("rst_addr", bus.mem_addr, 16'h0000);
    chk("rst_wdata", bus.mem_wdata, 16'h0000);
    chk("rst_if_data", bus.if_data, 16'h0000);
    chk("rst_dm_data", bus.dm_data, 16'h0000);
    chk("rst_flags", {bus.if_done, bus.dm_done, bus.if_err, bus.dm_err}, 4'b0000);
    chk("rst_state", dbg_state, 2'd0);
    chk("rst_run", dbg_dm_run, 2'd0);
    chk("rst_stall", {bus.if_stall, bus.dm_stall}, 2'b00);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_txn(vecs[i], i);

    // simultaneous fetch and data write, k=0
    bus.if_rd = 1'b1; bus.if_addr = 16'h0050;
    bus.dm_wr = 1'b1; bus.dm_addr = 16'h0040; bus.dm_wdata = 16'hBEEF;
    tick();
    chk("sim_c1_op", {bus.mem_rd, bus.mem_wr}, 2'b01);
    chk("sim_c1_addr", bus.mem_addr, 16'h0040);
    chk("sim_c1_wdata", bus.mem_wdata, 16'hBEEF);
    chk("sim_c1_run", dbg_dm_run, 2'd1);
    chk("sim_c1_if_stall", bus.if_stall, 1);
    bus.mem_done = 1'b1;
    tick();
    bus.mem_done = 1'b0;
    chk("sim_c2_dm_done", {bus.dm_done, bus.if_done}, 2'b10);
    bus.dm_wr = 1'b0;
    tick();
    chk("sim_c3_idle_op", {bus.mem_rd, bus.mem_wr}, 2'b00);
    tick();
    chk("sim_c4_if_gnt", {bus.mem_rd, bus.mem_wr}, 2'b10);
    chk("sim_c4_addr", bus.mem_addr, 16'h0050);
    chk("sim_c4_run", dbg_dm_run, 2'd0);
    bus.mem_done = 1'b1; bus.mem_rdata = 16'h7777;
    tick();
    bus.mem_done = 1'b0;
    chk("sim_c5_if_done", bus.if_done, 1);
    chk("sim_c5_if_data", bus.if_data, 16'h7777);
    drive_idle();
    tick();

    // burst fairness with both sides held, DM_BURST=2
    exp_q = {2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd1};
    run_q = {2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
    bus.if_rd = 1'b1; bus.if_addr = 16'h0AAA;
    bus.dm_rd = 1'b1; bus.dm_addr = 16'h0DDD;
    begin
      int grants;
      logic [1:0] got;
      grants = 0;
      for (int c = 0; c < 60 && grants < 6; c++) begin
        tick();
        bus.mem_done = 1'b0;
        if (bus.mem_rd) begin
          got = (bus.mem_addr == 16'h0DDD) ? 2'd2 : 2'd1;
          chk($sformatf("burst_order%0d", grants), got, exp_q.pop_front());
          chk($sformatf("burst_run%0d", grants), dbg_dm_run, run_q.pop_front());
          grants++;
          bus.mem_rdata = 16'h4321;
          bus.mem_done  = 1'b1;
        end
      end
      chk("burst_grants", grants, 6);
    end
    tick();
    drive_idle();
    tick();
    tick();

    // reset while fetch is granted
    bus.if_rd = 1'b1; bus.if_addr = 16'h0060;
    tick();
    chk("rstm_gnt", bus.mem_rd, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstm_mem_rd_drop", bus.mem_rd, 0);
    chk("rstm_state", dbg_state, 2'd0);
    tick();
    chk("rstm_no_done", bus.if_done, 0);
    rst_n = 1'b1;
    tick();
    chk("rstm_regrant", bus.mem_rd, 1);
    chk("rstm_regrant_addr", bus.mem_addr, 16'h0060);
    chk("rstm_still_no_done", bus.if_done, 0);
    bus.mem_done = 1'b1; bus.mem_rdata = 16'h2468;
    tick();
    bus.mem_done = 1'b0;
    chk("rstm_done", bus.if_done, 1);
    chk("rstm_data", bus.if_data, 16'h2468);
    drive_idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
